// File: rtl/pwm_gen_multi_pkg.sv
// Shared definitions for the multi-channel PWM generator.
package pwm_gen_multi_pkg;

    // Prescaler counter width (matches the prescale port).
    localparam int unsigned PRESC_W = 8;

    // Per-channel waveform function.
    typedef enum logic [1:0] {
        MODE_LEFT  = 2'b00,   // high while cnt < c1
        MODE_RIGHT = 2'b01,   // high while cnt >= c1
        MODE_WIN   = 2'b10,   // high while c1 <= cnt < c2
        MODE_NWIN  = 2'b11    // inverse of MODE_WIN
    } pwm_mode_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow configuration, compare logic and registered output.
module pwm_chan
    import pwm_gen_multi_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] c1_i,
    input  logic [WIDTH-1:0] c2_i,
    input  logic [1:0]       mode_i,
    input  logic             pol_i,
    input  logic             chen_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] c1_q, c1_d;
    logic [WIDTH-1:0] c2_q, c2_d;
    pwm_mode_e        mode_q, mode_d;
    logic             pol_q, pol_d;
    logic             chen_q, chen_d;
    logic             pwm_q, pwm_d;
    logic             in_win_c;
    logic             raw_c;

    // Shadow reload and next output level from the current count.
    always_comb begin
        c1_d   = c1_q;
        c2_d   = c2_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        chen_d = chen_q;
        raw_c  = 1'b0;

        if (load_i) begin
            c1_d   = c1_i;
            c2_d   = c2_i;
            mode_d = pwm_mode_e'(mode_i);
            pol_d  = pol_i;
            chen_d = chen_i;
        end

        // An empty window (c2 <= c1) is naturally never satisfied.
        in_win_c = (cnt_i >= c1_q) && (cnt_i < c2_q);

        unique case (mode_q)
            MODE_LEFT:  raw_c = (cnt_i < c1_q);
            MODE_RIGHT: raw_c = (cnt_i >= c1_q);
            MODE_WIN:   raw_c = in_win_c;
            MODE_NWIN:  raw_c = !in_win_c;
            default:    raw_c = 1'b0;
        endcase

        pwm_d = (en_i && chen_q) ? (raw_c ^ pol_q) : pol_q;
    end

    // Shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q   <= '0;
            c2_q   <= '0;
            mode_q <= MODE_LEFT;
            pol_q  <= 1'b0;
            chen_q <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            chen_q <= chen_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared prescaler/counter, synchronised config update.
module pwm_gen_multi
    import pwm_gen_multi_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     period,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic [NCH*WIDTH-1:0] compare1,
    input  logic [NCH*WIDTH-1:0] compare2,
    input  logic [NCH*2-1:0]     mode,
    input  logic [NCH-1:0]       polarity,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 upd_req,
    output logic                 upd_ack,
    output logic [WIDTH-1:0]     cnt_val,
    output logic                 period_tick,
    output logic [NCH-1:0]       pwm_out
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               upd_ack_q, upd_ack_d;
    logic               tick_q, tick_d;
    logic [WIDTH-1:0]   per_sh_q, per_sh_d;
    logic [PRESC_W-1:0] pre_sh_q, pre_sh_d;
    logic               step_c;
    logic               wrap_c;
    logic               load_c;

    // Prescaler, counter and update-request control.
    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        upd_ack_d = 1'b0;
        tick_d    = 1'b0;
        per_sh_d  = per_sh_q;
        pre_sh_d  = pre_sh_q;
        step_c    = 1'b0;
        wrap_c    = 1'b0;
        load_c    = 1'b0;

        if (!en) begin
            // Stopped: track inputs continuously and ack any request at once.
            presc_d   = '0;
            cnt_d     = '0;
            pending_d = 1'b0;
            upd_ack_d = upd_req;
            load_c    = 1'b1;
        end else begin
            step_c = (presc_q == pre_sh_q);
            wrap_c = step_c && (cnt_q >= per_sh_q);
            if (step_c) begin
                presc_d = '0;
                cnt_d   = wrap_c ? '0 : cnt_q + WIDTH'(1);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            tick_d = wrap_c;
            // New config only at a period boundary so no period is cut short.
            load_c    = wrap_c && (pending_q || upd_req);
            upd_ack_d = load_c;
            pending_d = load_c ? 1'b0 : (pending_q || upd_req);
        end

        if (load_c) begin
            per_sh_d = period;
            pre_sh_d = prescale;
        end
    end

    // Timebase and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            upd_ack_q <= 1'b0;
            tick_q    <= 1'b0;
            per_sh_q  <= '0;
            pre_sh_q  <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            upd_ack_q <= upd_ack_d;
            tick_q    <= tick_d;
            per_sh_q  <= per_sh_d;
            pre_sh_q  <= pre_sh_d;
        end
    end

    // Channel instances share the counter and load strobe.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pwm_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en),
            .load_i (load_c),
            .cnt_i  (cnt_q),
            .c1_i   (compare1[g*WIDTH +: WIDTH]),
            .c2_i   (compare2[g*WIDTH +: WIDTH]),
            .mode_i (mode[g*2 +: 2]),
            .pol_i  (polarity[g]),
            .chen_i (ch_en[g]),
            .pwm_o  (pwm_out[g])
        );
    end

    assign upd_ack     = upd_ack_q;
    assign cnt_val     = cnt_q;
    assign period_tick = tick_q;

endmodule
